// File: rtl/lif_membrane_update_pkg.sv
// Shared types and constants for the LIF membrane stage and its neighbours.
package lif_pkg;

    typedef enum logic {
        ACTIVE = 1'b0,
        REFRAC = 1'b1
    } lif_state_t;

    localparam int LEAK_SHIFT_W         = 2;
    localparam int DEFAULT_WIDTH        = 6;
    localparam int DEFAULT_REFRAC_WIDTH = 3;

endpackage

// File: rtl/lif_membrane_update_refractory_timer.sv
// Refractory down-counter: load on spike, decrement on each ignored step,
// and flag the final ignored step (count == 1).
module refractory_timer #(
    parameter int REFRAC_WIDTH = lif_pkg::DEFAULT_REFRAC_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [REFRAC_WIDTH-1:0] load_val,
    input  logic                    dec,
    output logic                    last
);

    localparam logic [REFRAC_WIDTH-1:0] ONE = {{(REFRAC_WIDTH-1){1'b0}}, 1'b1};

    logic [REFRAC_WIDTH-1:0] count_q;
    logic [REFRAC_WIDTH-1:0] count_d;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == ONE);

endmodule

// File: rtl/lif_membrane_update.sv
// LIF membrane state: leak, threshold fire, membrane reset and refractory
// period, one update per step strobe.
// Optional macro LIF_RESET_BY_SUBTRACTION_EN: on spike the membrane keeps
// u_bn - threshold instead of being cleared to zero.
//
// state  | meaning
// ACTIVE | steps integrate u_bn with leak and may fire
// REFRAC | steps ignore u_bn until the loaded period has elapsed
module lif_membrane_update
    import lif_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int REFRAC_WIDTH = DEFAULT_REFRAC_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      step,
    input  logic signed [WIDTH-1:0]   u_bn,
    input  logic [WIDTH-2:0]          threshold,
    input  logic [LEAK_SHIFT_W-1:0]   leak_shift,
    input  logic [REFRAC_WIDTH-1:0]   refrac_cycles,
    output logic signed [WIDTH-1:0]   u,
    output logic                      spike,
    output logic                      refractory
);

    lif_state_t              state_q;
    lif_state_t              state_d;
    logic signed [WIDTH-1:0] u_q;
    logic signed [WIDTH-1:0] u_d;
    logic                    spike_q;
    logic                    spike_d;

    logic                    tmr_load;
    logic                    tmr_dec;
    logic                    tmr_last;

    logic signed [WIDTH-1:0] thr_ext;
    logic signed [WIDTH-1:0] decay;
    logic signed [WIDTH-1:0] leaked;
    logic signed [WIDTH-1:0] reset_val;
    logic                    fire;

    // Threshold is unsigned, so the zero-extended value is always nonnegative.
    assign thr_ext = $signed({1'b0, threshold});
    assign fire    = (u_bn >= thr_ext);
    // Decay shares the sign of u_bn and is no larger, so the difference fits.
    assign decay   = u_bn >>> leak_shift;
    assign leaked  = u_bn - decay;

`ifdef LIF_RESET_BY_SUBTRACTION_EN
    assign reset_val = u_bn - thr_ext;
`else
    assign reset_val = '0;
`endif

    refractory_timer #(
        .REFRAC_WIDTH (REFRAC_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (refrac_cycles),
        .dec      (tmr_dec),
        .last     (tmr_last)
    );

    // Next-state, membrane and spike decode; nothing moves without step.
    always_comb begin
        state_d  = state_q;
        u_d      = u_q;
        spike_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        if (step) begin
            case (state_q)
                ACTIVE: begin
                    if (fire) begin
                        spike_d  = 1'b1;
                        u_d      = reset_val;
                        tmr_load = 1'b1;
                        if (refrac_cycles != '0) begin
                            state_d = REFRAC;
                        end
                    end else begin
                        u_d = leaked;
                    end
                end
                REFRAC: begin
                    tmr_dec = 1'b1;
                    if (tmr_last) begin
                        state_d = ACTIVE;
                    end
                end
                default: begin
                    state_d = ACTIVE;
                end
            endcase
        end
    end

    // State, membrane and spike registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACTIVE;
            u_q     <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            spike_q <= spike_d;
        end
    end

    assign u          = u_q;
    assign spike      = spike_q;
    assign refractory = (state_q == REFRAC);

endmodule

// File: tb/tb_lif_membrane_update.sv
// Scoreboard bench for lif_membrane_update: the driver pushes the expected
// outputs from an integer reference model, the monitor pops and compares.
module tb_lif_membrane_update;

    localparam int W  = 6;
    localparam int RW = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 step = 1'b0;
    logic signed [W-1:0]  u_bn = '0;
    logic [W-2:0]         threshold = '0;
    logic [1:0]           leak_shift = '0;
    logic [RW-1:0]        refrac_cycles = '0;
    logic signed [W-1:0]  u;
    logic                 spike;
    logic                 refractory;

    lif_membrane_update #(
        .WIDTH        (W),
        .REFRAC_WIDTH (RW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .step          (step),
        .u_bn          (u_bn),
        .threshold     (threshold),
        .leak_shift    (leak_shift),
        .refrac_cycles (refrac_cycles),
        .u             (u),
        .spike         (spike),
        .refractory    (refractory)
    );

    always #5 clk = ~clk;

    typedef struct {
        int u;
        int spike;
        int refr;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: membrane value and number of steps still to ignore.
    int   m_u    = 0;
    int   m_left = 0;

`ifdef LIF_RESET_BY_SUBTRACTION_EN
    localparam bit RBS = 1'b1;
`else
    localparam bit RBS = 1'b0;
`endif

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // floor(v / 2^s) with plain integer division.
    function automatic int floor_div_pow2(input int v, input int s);
        int d;
        d = 1 << s;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    task automatic cyc(input bit st, input int ub, input int thr, input int ls, input int rc);
        exp_t e;
        @(negedge clk);
        step          = st;
        u_bn          = W'(ub);
        threshold     = (W-1)'(thr);
        leak_shift    = 2'(ls);
        refrac_cycles = RW'(rc);
        e.spike = 0;
        if (st) begin
            if (m_left > 0) begin
                m_left--;
            end else if (ub >= thr) begin
                e.spike = 1;
                m_u     = RBS ? (ub - thr) : 0;
                m_left  = rc;
            end else begin
                m_u = ub - floor_div_pow2(ub, ls);
            end
        end
        e.u    = m_u;
        e.refr = (m_left > 0) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        step = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_u"}, int'(u), 0);
        check({tag, "_spike"}, int'(spike), 0);
        check({tag, "_refractory"}, int'(refractory), 0);
        #1 rst_n = 1'b1;
        m_u    = 0;
        m_left = 0;
    endtask

    // Monitor: one expected entry per driven cycle, checked after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("u", int'(u), e.u);
                check("spike", int'(spike), e.spike);
                check("refractory", int'(refractory), e.refr);
            end
        end
    end

    initial begin
        int ub;
        #2;
        check("rst_u", int'(u), 0);
        check("rst_spike", int'(spike), 0);
        check("rst_refractory", int'(refractory), 0);
        #10 rst_n = 1'b1;

        // Leak without firing.
        cyc(1, 10, 12, 2, 0);
        cyc(1, -9, 12, 1, 0);
        cyc(1, -32, 12, 1, 0);

        // Fire with no refractory period; stays active and can fire again.
        cyc(1, 20, 12, 0, 0);
        cyc(0, 20, 12, 0, 0);
        cyc(1, 20, 12, 0, 0);

        // Refractory of 3; later refrac_cycles changes must not matter.
        cyc(1, 31, 12, 0, 3);
        cyc(1, 31, 12, 0, 7);
        cyc(1, 31, 12, 0, 7);
        cyc(1, 31, 12, 0, 7);
        cyc(1, 31, 12, 0, 0);

        // Threshold equality edge.
        cyc(1, 31, 31, 0, 0);
        cyc(1, 30, 31, 0, 0);

        // Step idle inside a refractory period.
        cyc(1, 25, 12, 0, 2);
        for (int i = 0; i < 5; i++) cyc(0, (i % 2) ? 31 : -32, 12, 0, 2);
        cyc(1, 31, 12, 0, 2);
        cyc(1, 31, 12, 0, 2);
        cyc(1, 31, 12, 0, 2);

        // Threshold zero fires on zero.
        cyc(1, 0, 0, 0, 0);

        // Async reset mid-refractory (counter at 2).
        cyc(1, 31, 12, 0, 3);
        cyc(1, 31, 12, 0, 3);
        async_reset("midrefrac_rst");
        cyc(1, 31, 12, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ub = int'($urandom_range(63)) - 32;
            cyc(($urandom_range(9) < 7), ub, int'($urandom_range(31)),
                int'($urandom_range(3)), int'($urandom_range(7)));
        end

        @(negedge clk);
        step = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lif_membrane_update.md
# lif_membrane_update

Membrane-state stage of the LIF neuron, directly downstream of `batch_normalization`. It registers the batch-normalized potential as the neuron's membrane state and applies leak. It fires a spike on threshold crossing, resets the membrane, and enforces a refractory period. The registered membrane value `u` is fed back as the `u` input of `batch_normalization`, which closes the per-timestep loop.

## Interface
Parameters:
- `WIDTH`, 6: signed membrane/potential width; must match `batch_normalization` `WIDTH`.
- `REFRAC_WIDTH`, 3: refractory counter width.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `step`  in  1  timestep strobe; each cycle sampled high is one timestep.
- `u_bn`  in  WIDTH signed  `u_out` of `batch_normalization` (computed from current `u`).
- `threshold`  in  WIDTH-1 unsigned  firing threshold, zero-extended to WIDTH (always ≥0).
- `leak_shift`  in  2  leak amount: decay = `u_bn >>> leak_shift`; 0 = no leak.
- `refrac_cycles`  in  REFRAC_WIDTH  number of timesteps ignored after a spike.
- `u`  out  WIDTH signed  registered membrane potential.
- `spike`  out  1  registered spike, one-cycle pulse.
- `refractory`  out  1  high while in REFRAC state.

## Operation
- States: ACTIVE, REFRAC.
- Every update occurs only on a cycle with `step`=1. Without `step`: `u`, state and counter hold, `spike`=0.
- ACTIVE, step:
  - If `u_bn >= threshold` (signed compare):
    - `spike`←1, `u`←reset value (see Configuration), counter←`refrac_cycles`.
    - Next state is REFRAC if `refrac_cycles`≠0, else ACTIVE.
  - Otherwise `u` ← `u_bn − (u_bn >>> leak_shift)` and `spike`←0.
    - `leak_shift`=0 yields `u_bn` unchanged.
    - Arithmetic shift; the result cannot overflow WIDTH because the decay has the same sign as `u_bn` and no greater magnitude.
- REFRAC, step:
  - `u_bn` is ignored, `u` holds, `spike`←0, counter decrements.
  - When the counter is 1 on that step, next state is ACTIVE.
  - Exactly `refrac_cycles` steps are ignored.
- `refrac_cycles` is sampled only at spike time; later changes do not affect the running period.
- `threshold`=0: any nonnegative `u_bn` in ACTIVE fires.

## Timing
- Reset (async, immediate): `u`=0, `spike`=0, `refractory`=0, state ACTIVE, counter 0.
- Reset asserted mid-refractory aborts the period; the first step after release is evaluated in ACTIVE.
- Latency: one cycle. Values are sampled on the rising edge with `step`=1, and `u` and `spike` are valid after that edge.
- The combinational path `u` → `batch_normalization` → `u_bn` → `u` register must close in one cycle.
- With `step` held high on consecutive cycles, each cycle is a step.
- A spike asserts for the cycle after its step only, and is never asserted on two consecutive cycles when `refrac_cycles`≠0.

## Configuration
- `LIF_RESET_BY_SUBTRACTION_EN`:
  - Defined: on spike, `u` ← `u_bn − threshold`. This is always in [0, 2^(WIDTH-1)−1], so no saturation is needed.
  - Undefined: on spike, `u` ← 0 (reset to zero).

## Structure
- Package `lif_pkg`:
  - state typedef (`ACTIVE`, `REFRAC`);
  - leak-shift width constant (2);
  - default `WIDTH`/`REFRAC_WIDTH` constants shared with `batch_normalization` instantiation.
- One sub-module, `refractory_timer`: counter with load, decrement-on-step, and a `last` flag (counter==1).

## Test plan
- Async reset during REFRAC (counter=2) → `u`=0, `spike`=0, `refractory`=0 with no clock edge; the next step with `u_bn`=31, `threshold`=12 spikes.
- Leak, ACTIVE, no fire:
  - `u_bn`=10, `threshold`=12, `leak_shift`=2, step → `u`=8, `spike`=0.
  - `u_bn`=−9, `leak_shift`=1 → `u`=−4.
  - `u_bn`=−32, `leak_shift`=1 → `u`=−16.
- Fire: `u_bn`=20, `threshold`=12, `refrac_cycles`=0, step → `spike`=1 for one cycle and state stays ACTIVE; `u`=0, or `u`=8 with `LIF_RESET_BY_SUBTRACTION_EN`.
- Refractory:
  - `refrac_cycles`=3: spike, then three steps with `u_bn`=31 → `spike`=0, `u` held, `refractory`=1.
  - The fourth step with `u_bn`=31 → `spike`=1.
- Equality edge: `threshold`=31, `u_bn`=31 → spike; `u_bn`=30 → no spike, `u`=30 (`leak_shift`=0).
- `step`=0 for 5 cycles while `u_bn` toggles → `u`, `refractory`, counter unchanged, `spike`=0.
